// File: rtl/mavg_channel_sched.sv
// Two-channel round-robin scheduler in front of a shared moving-average datapath.
// One datapath transaction is outstanding at a time; flush requests are folded
// into the same request stream ahead of samples, and each channel's results are
// withheld until that channel's window of WIN samples has filled.
module mavg_channel_sched #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch0_valid,
  input  logic [DATA_W-1:0] ch0_data,
  output logic              ch0_ready,
  input  logic              ch1_valid,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              ch1_ready,
  input  logic              flush0,
  input  logic              flush1,
  output logic              dp_valid,
  output logic              dp_ch,
  output logic              dp_flush,
  output logic [DATA_W-1:0] dp_data,
  input  logic              dp_ready,
  input  logic              dp_res_valid,
  input  logic              dp_res_ch,
  input  logic [DATA_W-1:0] dp_res_data,
  output logic              out0_valid,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  output logic              busy,
  output logic              err
);

  // Warm-up counter only needs to reach WIN, where it saturates.
  localparam int            CW    = (WIN > 1) ? $clog2(WIN + 1) : 1;
  localparam logic [CW-1:0] WIN_C = CW'(WIN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RES = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Registered request presented to the datapath while in ISSUE.
  logic              r_dp_ch;
  logic              r_dp_flush;
  logic [DATA_W-1:0] r_dp_data;
  // Channel granted most recently; reset to 1 so channel 0 wins the first tie.
  logic              r_last;
  logic              r_err;

  logic                   w_idle;
  logic                   w_any_pend;
  logic                   w_res_ok;
  logic                   w_res_bad;
  logic [1:0]             w_pend;
  logic [1:0]             w_grant;
  logic [1:0]             w_take_flush;
  logic [1:0]             w_take_sample;
  logic [1:0]             w_res_hit;
  logic [1:0]             w_flush_in;
  logic [1:0]             w_out_valid;
  logic [1:0][DATA_W-1:0] w_out_data;

  assign w_idle     = (r_state == S_IDLE);
  assign w_flush_in = {flush1, flush0};
  assign w_any_pend = |w_pend;

  // Round-robin: with both channels requesting, the one not granted last wins.
  assign w_grant[0] = ch0_valid & (~ch1_valid | r_last);
  assign w_grant[1] = ch1_valid & (~ch0_valid | ~r_last);

  // Pending flushes beat samples, and flush 0 beats flush 1.
  assign w_take_flush[0] = w_idle & w_pend[0];
  assign w_take_flush[1] = w_idle & w_pend[1] & ~w_pend[0];

  // Per-channel state: flush pending bit, warm-up counter and result output.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic CH = (gi == 1) ? 1'b1 : 1'b0;

      logic              r_pend;
      logic [CW-1:0]     r_warm;
      logic              r_out_valid;
      logic [DATA_W-1:0] r_out_data;
      logic [CW-1:0]     w_warm_inc;

      // A flush arriving this cycle already counts as pending, so it beats a
      // same-cycle sample on either channel.
      assign w_pend[gi]        = r_pend | w_flush_in[gi];
      assign w_take_sample[gi] = w_idle & ~w_any_pend & w_grant[gi];
      assign w_res_hit[gi]     = w_res_ok & (r_dp_ch == CH);
      assign w_warm_inc        = (r_warm == WIN_C) ? WIN_C : r_warm + 1'b1;
      assign w_out_valid[gi]   = r_out_valid;
      assign w_out_data[gi]    = r_out_data;

      // Track flush requests, warm-up progress and emit unsuppressed results.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pend      <= 1'b0;
          r_warm      <= '0;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
        end else begin
          r_pend      <= w_pend[gi] & ~w_take_flush[gi];
          r_out_valid <= 1'b0;
          if (w_take_flush[gi]) begin
            r_warm <= '0;
          end else if (w_res_hit[gi]) begin
            r_warm <= w_warm_inc;
            if (w_warm_inc == WIN_C) begin
              r_out_valid <= 1'b1;
              r_out_data  <= dp_res_data;
            end
          end
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and result classification.
  always_comb begin
    w_state_next = r_state;
    w_res_ok     = 1'b0;
    w_res_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_res_bad = dp_res_valid;
        if ((|w_take_flush) || (|w_take_sample)) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_res_bad = dp_res_valid;
        if (dp_ready) begin
          // Flushes produce no result, so they return straight to IDLE.
          w_state_next = r_dp_flush ? S_IDLE : S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (dp_res_valid) begin
          if (dp_res_ch == r_dp_ch) begin
            w_res_ok     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_res_bad = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture the selected request and update the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_ch    <= 1'b0;
      r_dp_flush <= 1'b0;
      r_dp_data  <= '0;
      r_last     <= 1'b1;
    end else if (w_take_flush[0]) begin
      r_dp_ch    <= 1'b0;
      r_dp_flush <= 1'b1;
      r_dp_data  <= '0;
    end else if (w_take_flush[1]) begin
      r_dp_ch    <= 1'b1;
      r_dp_flush <= 1'b1;
      r_dp_data  <= '0;
    end else if (w_take_sample[0]) begin
      r_dp_ch    <= 1'b0;
      r_dp_flush <= 1'b0;
      r_dp_data  <= ch0_data;
      r_last     <= 1'b0;
    end else if (w_take_sample[1]) begin
      r_dp_ch    <= 1'b1;
      r_dp_flush <= 1'b0;
      r_dp_data  <= ch1_data;
      r_last     <= 1'b1;
    end
  end

  // Sticky protocol error: unexpected or misrouted results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_res_bad) begin
      r_err <= 1'b1;
    end
  end

  assign ch0_ready  = w_take_sample[0];
  assign ch1_ready  = w_take_sample[1];
  assign dp_valid   = (r_state == S_ISSUE);
  assign dp_ch      = r_dp_ch;
  assign dp_flush   = r_dp_flush;
  assign dp_data    = r_dp_data;
  assign out0_valid = w_out_valid[0];
  assign out0_data  = w_out_data[0];
  assign out1_valid = w_out_valid[1];
  assign out1_data  = w_out_data[1];
  assign busy       = ~w_idle;
  assign err        = r_err;

endmodule

// File: tb/tb_mavg_channel_sched.sv
// Directed bench for mavg_channel_sched: warm-up suppression, round-robin,
// ISSUE stall, flush serialisation, wrong-channel results and mid-flight reset.
module tb_mavg_channel_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       ch0_valid, ch1_valid, ch0_ready, ch1_ready;
  logic [7:0] ch0_data, ch1_data;
  logic       flush0, flush1;
  logic       dp_valid, dp_ch, dp_flush, dp_ready;
  logic [7:0] dp_data;
  logic       dp_res_valid, dp_res_ch;
  logic [7:0] dp_res_data;
  logic       out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data;
  logic       busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  mavg_channel_sched #(.DATA_W(8), .WIN(4)) dut (
    .clk(clk), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
    .flush0(flush0), .flush1(flush1),
    .dp_valid(dp_valid), .dp_ch(dp_ch), .dp_flush(dp_flush), .dp_data(dp_data),
    .dp_ready(dp_ready),
    .dp_res_valid(dp_res_valid), .dp_res_ch(dp_res_ch), .dp_res_data(dp_res_data),
    .out0_valid(out0_valid), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_data(out1_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample transaction with zero-wait datapath and immediate result.
  task automatic txn(input logic exp_ch, input logic [7:0] exp_data,
                     input logic [7:0] res, input logic exp_out);
    #1;
    check_eq("txn_ready", exp_ch ? ch1_ready : ch0_ready, 1);
    check_eq("txn_other_ready", exp_ch ? ch0_ready : ch1_ready, 0);
    step();
    check_eq("txn_dp_valid", dp_valid, 1);
    check_eq("txn_dp_ch", dp_ch, exp_ch);
    check_eq("txn_dp_flush", dp_flush, 0);
    check_eq("txn_dp_data", dp_data, exp_data);
    dp_ready = 1'b1;
    step();
    dp_ready = 1'b0;
    check_eq("txn_dp_valid_drop", dp_valid, 0);
    check_eq("txn_busy_wait", busy, 1);
    dp_res_valid = 1'b1;
    dp_res_ch    = exp_ch;
    dp_res_data  = res;
    step();
    dp_res_valid = 1'b0;
    check_eq("txn_out_valid", exp_ch ? out1_valid : out0_valid, exp_out);
    check_eq("txn_other_out_valid", exp_ch ? out0_valid : out1_valid, 0);
    if (exp_out) check_eq("txn_out_data", exp_ch ? out1_data : out0_data, res);
    check_eq("txn_busy_idle", busy, 0);
    $display("TXN ch=%0d data=%02h res=%02h out=%0d", exp_ch, exp_data, res, exp_out);
  endtask

  initial begin
    rst = 1'b1;
    ch0_valid = 0; ch1_valid = 0; ch0_data = 0; ch1_data = 0;
    flush0 = 0; flush1 = 0; dp_ready = 0;
    dp_res_valid = 0; dp_res_ch = 0; dp_res_data = 0;

    // 1: reset state, then ch0 warm-up with echoing datapath
    repeat (3) step();
    rst = 1'b0;
    check_eq("rst_dp_valid", dp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_out0_valid", out0_valid, 0);
    check_eq("rst_out0_data", out0_data, 0);
    check_eq("rst_out1_valid", out1_valid, 0);
    check_eq("rst_dp_data", dp_data, 0);
    check_eq("rst_ready0", ch0_ready, 0);
    ch0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ch0_data = 8'((i + 1) * 16);
      txn(1'b0, ch0_data, ch0_data, 1'b0);
    end
    check_eq("warm_out0_held_zero", out0_data, 0);
    ch0_data = 8'h40;
    txn(1'b0, 8'h40, 8'h40, 1'b1);
    ch0_valid = 1'b0;

    // 2: both channels continuously valid after reset -> 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    ch0_valid = 1'b1; ch0_data = 8'hA0;
    ch1_valid = 1'b1; ch1_data = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) txn(1'b0, 8'hA0, 8'hA1, 1'b0);
      else            txn(1'b1, 8'hB0, 8'hB1, 1'b0);
    end

    // 3: datapath stalls 3 cycles in ISSUE
    ch1_valid = 1'b0; ch0_data = 8'h55;
    #1;
    check_eq("stall_ready0_idle", ch0_ready, 1);
    step();
    ch1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_dp_valid", dp_valid, 1);
      check_eq("stall_dp_ch", dp_ch, 0);
      check_eq("stall_dp_data", dp_data, 8'h55);
      check_eq("stall_ready0", ch0_ready, 0);
      check_eq("stall_ready1", ch1_ready, 0);
      step();
    end
    dp_ready = 1'b1;
    step();
    dp_ready = 1'b0; ch0_valid = 1'b0; ch1_valid = 1'b0;
    check_eq("stall_dp_valid_drop", dp_valid, 0);
    dp_res_valid = 1'b1; dp_res_ch = 1'b0; dp_res_data = 8'h66;
    step();
    dp_res_valid = 1'b0;
    check_eq("stall_out0_suppressed", out0_valid, 0);
    check_eq("stall_busy", busy, 0);
    $display("TXN stall ch=0 data=55 res=66");

    // 4: flush1 during ch0 WAIT_RES, then ch1 restarts warm-up
    ch0_valid = 1'b1; ch0_data = 8'h77;
    step();
    check_eq("fl_dp_ch0", dp_ch, 0);
    dp_ready = 1'b1;
    step();
    dp_ready = 1'b0; ch0_valid = 1'b0; flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    check_eq("fl_busy_wait", busy, 1);
    dp_res_valid = 1'b1; dp_res_ch = 1'b0; dp_res_data = 8'h78;
    step();
    dp_res_valid = 1'b0;
    check_eq("fl_out0_valid", out0_valid, 1);
    check_eq("fl_out0_data", out0_data, 8'h78);
    ch1_valid = 1'b1; ch1_data = 8'hC1;
    #1;
    check_eq("fl_ready1_blocked", ch1_ready, 0);
    step();
    check_eq("fl_dp_valid", dp_valid, 1);
    check_eq("fl_dp_flush", dp_flush, 1);
    check_eq("fl_dp_ch", dp_ch, 1);
    check_eq("fl_dp_data", dp_data, 0);
    dp_ready = 1'b1;
    step();
    dp_ready = 1'b0;
    check_eq("fl_back_idle", busy, 0);
    check_eq("fl_dp_valid_drop", dp_valid, 0);
    $display("TXN flush ch=1");
    for (int i = 0; i < 4; i++) txn(1'b1, 8'hC1, 8'(8'hD0 + i), i == 3);
    ch1_valid = 1'b0;

    // 5: misrouted result while waiting on ch0
    ch0_valid = 1'b1; ch0_data = 8'h99;
    step();
    dp_ready = 1'b1;
    step();
    dp_ready = 1'b0; ch0_valid = 1'b0;
    check_eq("err_before", err, 0);
    dp_res_valid = 1'b1; dp_res_ch = 1'b1; dp_res_data = 8'hEE;
    step();
    check_eq("err_set", err, 1);
    check_eq("err_busy", busy, 1);
    check_eq("err_out1_none", out1_valid, 0);
    dp_res_ch = 1'b0; dp_res_data = 8'h9A;
    step();
    dp_res_valid = 1'b0;
    check_eq("err_done_busy", busy, 0);
    check_eq("err_sticky", err, 1);
    check_eq("err_out0_valid", out0_valid, 1);
    check_eq("err_out0_data", out0_data, 8'h9A);
    $display("TXN misroute ch=0 res=9a err=%0d", err);

    // 6: reset while in ISSUE
    ch1_valid = 1'b1; ch1_data = 8'h31;
    step();
    check_eq("rst6_dp_valid_before", dp_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst6_dp_valid", dp_valid, 0);
    check_eq("rst6_busy", busy, 0);
    check_eq("rst6_err", err, 0);
    check_eq("rst6_out0_data", out0_data, 0);
    check_eq("rst6_out1_data", out1_data, 0);
    ch0_valid = 1'b1; ch0_data = 8'h01;
    txn(1'b0, 8'h01, 8'h11, 1'b0);
    txn(1'b1, 8'h31, 8'h32, 1'b0);
    ch0_valid = 1'b0; ch1_valid = 1'b0;

    // 7: result strobe in IDLE
    dp_res_valid = 1'b1; dp_res_ch = 1'b0; dp_res_data = 8'h5A;
    step();
    dp_res_valid = 1'b0;
    check_eq("idle_res_err", err, 1);
    check_eq("idle_res_out0", out0_valid, 0);
    check_eq("idle_res_busy", busy, 0);
    $display("TXN stray result in IDLE err=%0d", err);

    // 8: flush and sample on the same channel in the same cycle
    ch0_valid = 1'b1; ch0_data = 8'h42; flush0 = 1'b1;
    #1;
    check_eq("same_ready0", ch0_ready, 0);
    step();
    flush0 = 1'b0;
    check_eq("same_dp_flush", dp_flush, 1);
    check_eq("same_dp_ch", dp_ch, 0);
    check_eq("same_dp_data", dp_data, 0);
    dp_ready = 1'b1;
    step();
    dp_ready = 1'b0;
    check_eq("same_idle", busy, 0);
    $display("TXN flush ch=0 beats sample");
    txn(1'b0, 8'h42, 8'h43, 1'b0);
    ch0_valid = 1'b0;

    // 9: both flushes together -> ch0 first, then ch1
    flush0 = 1'b1; flush1 = 1'b1;
    step();
    flush0 = 1'b0; flush1 = 1'b0;
    check_eq("dual_first_ch", dp_ch, 0);
    check_eq("dual_first_flush", dp_flush, 1);
    dp_ready = 1'b1;
    step();
    step();
    check_eq("dual_second_ch", dp_ch, 1);
    check_eq("dual_second_flush", dp_flush, 1);
    check_eq("dual_second_valid", dp_valid, 1);
    step();
    dp_ready = 1'b0;
    check_eq("dual_idle", busy, 0);
    $display("TXN dual flush ch0 then ch1");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
